// File: rtl/gf_alu_pipe.sv
// gf_alu_pipe: GF(2^M) arithmetic unit in index encoding (0 = zero, k = alpha^(k-1)).
// ADD/MUL/DIV finish in one cycle. POW is iterative, one exponent bit per cycle.
// Result handshake is valid/ready, and a new request can be accepted while a held result is consumed.
// Build option: define GF_POW_EN to include the POW datapath and BUSY state.
// Without it, op=3 completes in one cycle with out=0, err=1.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no result held, ready for a request
//   BUSY  | POW iterating over exponent bits, MSB first (GF_POW_EN only)
//   HOLD  | result on out/err, waiting for out_ready
module gf_alu_pipe #(
    parameter int         M    = 3,
    parameter logic [M:0] POLY = 4'b1011
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out,
    output logic         err
);

    localparam int         Q   = 1 << M;
    localparam int         N   = Q - 1;
    localparam logic [M:0] N_W = N[M:0];
    localparam logic [M-1:0] ONE = 1;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_DIV = 2'd2;

`ifdef GF_POW_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;
    localparam int CW = $clog2(M + 1);
`else
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_t;
`endif

    state_t         state;
    logic [M-1:0]   out_r;
    logic           err_r;
    logic           accept;

    // Polynomial value of a code: alpha^(k-1) reduced modulo POLY. Code 0 maps to 0.
    function automatic logic [M-1:0] code_to_poly(input int k);
        logic [M:0] v;
        v = {{M{1'b0}}, 1'b1};
        for (int i = 1; i < Q; i++) begin
            if (i < k) begin
                v = {v[M-1:0], 1'b0};
                if (v[M]) v = v ^ POLY;
            end
        end
        return (k == 0) ? '0 : v[M-1:0];
    endfunction

    // Inverse of code_to_poly. Value 0 matches no nonzero code, so it stays code 0.
    function automatic logic [M-1:0] poly_to_code(input int p);
        logic [M-1:0] r;
        r = '0;
        for (int k = 1; k < Q; k++) begin
            if (code_to_poly(k) == p[M-1:0]) r = k[M-1:0];
        end
        return r;
    endfunction

    logic [M-1:0] antilog_tbl [Q];
    logic [M-1:0] log_tbl     [Q];

    for (genvar k = 0; k < Q; k++) begin : g_tbl
        assign antilog_tbl[k] = code_to_poly(k);
        assign log_tbl[k]     = poly_to_code(k);
    end

    // Single-cycle datapath: exponent sums and differences are kept in 0..2N-1, then one conditional subtract.
    logic [M-1:0] ea, eb, res_comb;
    logic [M:0]   sum_e, diff_e, mul_e, div_e;
    logic         err_comb;
    always_comb begin
        ea       = a - ONE;
        eb       = b - ONE;
        sum_e    = {1'b0, ea} + {1'b0, eb};
        mul_e    = (sum_e >= N_W) ? sum_e - N_W : sum_e;
        diff_e   = {1'b0, ea} + (N_W - {1'b0, eb});
        div_e    = (diff_e >= N_W) ? diff_e - N_W : diff_e;
        res_comb = '0;
        err_comb = 1'b0;
        case (op)
            OP_ADD: res_comb = log_tbl[antilog_tbl[a] ^ antilog_tbl[b]];
            OP_MUL: res_comb = (a == '0 || b == '0) ? '0 : mul_e[M-1:0] + ONE;
            OP_DIV: begin
                err_comb = (b == '0);
                res_comb = (a == '0 || b == '0) ? '0 : div_e[M-1:0] + ONE;
            end
            default: begin
                res_comb = '0;
                err_comb = 1'b1;
            end
        endcase
    end

`ifdef GF_POW_EN
    logic [M-1:0]  acc, acc_nxt, pow_ea, pow_b, pow_res;
    logic          pow_a_zero;
    logic [CW-1:0] bit_cnt;
    logic [M:0]    dbl, dbl_m, stp, stp_m;

    // One POW step: acc = (2*acc + b[i]*(a-1)) mod N, which keeps acc < N.
    always_comb begin
        dbl     = {acc, 1'b0};
        dbl_m   = (dbl >= N_W) ? dbl - N_W : dbl;
        stp     = dbl_m + (pow_b[bit_cnt] ? {1'b0, pow_ea} : '0);
        stp_m   = (stp >= N_W) ? stp - N_W : stp;
        acc_nxt = stp_m[M-1:0];
        if (pow_a_zero) pow_res = (pow_b == '0) ? ONE : '0;
        else            pow_res = acc_nxt + ONE;
    end
`endif

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state == IDLE) || (state == HOLD && out_ready);
    assign out_valid = (state == HOLD);
    assign out       = out_r;
    assign err       = err_r;

    // Control FSM. The result register only loads on a completion, so out/err are stable in HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            out_r <= '0;
            err_r <= 1'b0;
`ifdef GF_POW_EN
            acc        <= '0;
            bit_cnt    <= '0;
            pow_ea     <= '0;
            pow_b      <= '0;
            pow_a_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
`ifdef GF_POW_EN
                        if (op == 2'd3) begin
                            acc        <= '0;
                            bit_cnt    <= CW'(M - 1);
                            pow_ea     <= (a == '0) ? '0 : a - ONE;
                            pow_b      <= b;
                            pow_a_zero <= (a == '0);
                            state      <= BUSY;
                        end else begin
                            out_r <= res_comb;
                            err_r <= err_comb;
                            state <= HOLD;
                        end
`else
                        out_r <= res_comb;
                        err_r <= err_comb;
                        state <= HOLD;
`endif
                    end else if (state == HOLD && out_ready) begin
                        state <= IDLE;
                    end
                end
`ifdef GF_POW_EN
                BUSY: begin
                    acc <= acc_nxt;
                    if (bit_cnt == '0) begin
                        out_r <= pow_res;
                        err_r <= 1'b0;
                        state <= HOLD;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
